// File: rtl/dec_share_arbiter.sv
// Round-robin scheduler sharing one combinational decrement unit among NREQ requesters.
// Flow per operation: IDLE (arbitrate, latch operand) -> ISSUE -> WAIT (DEC_LAT cycles)
// -> RESP (capture result, pulse ack) -> IDLE.
// Optional build macro DEC_SHARE_SATURATE_EN: operand 0 returns 0 instead of wrapping.
module dec_share_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEC_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      res_out,
  output logic                  borrow_out,
  output logic [WIDTH-1:0]      dec_a,
  input  logic [WIDTH-1:0]      dec_s,
  output logic                  busy
);

  localparam int unsigned IdxW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   gidx_q;
  logic [3:0]        cnt_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   ack_q;
  logic [WIDTH-1:0]  res_q;
  logic              borrow_q;
  logic [WIDTH-1:0]  dec_a_q;

  logic              win_found;
  logic [IdxW-1:0]   win_idx;
  logic [WIDTH-1:0]  win_op;
  int unsigned       cand;

  // First set request searching upward from the pointer, wrapping at NREQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_op    = '0;
    cand      = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = (32'(ptr_q) + off) % NREQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(cand);
        win_op    = op_in[cand*WIDTH +: WIDTH];
      end
    end
  end

  // Operation sequencer; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      gidx_q   <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      dec_a_q  <= '0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            gidx_q         <= win_idx;
            gnt_q          <= '0;
            gnt_q[win_idx] <= 1'b1;
            dec_a_q        <= win_op;
            state_q        <= StIssue;
          end
        end
        StIssue: begin
          cnt_q   <= 4'(DEC_LAT - 1);
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
`ifdef DEC_SHARE_SATURATE_EN
          res_q <= (dec_a_q == '0) ? '0 : dec_s;
`else
          res_q <= dec_s;
`endif
          borrow_q <= (dec_a_q == '0);
          ack_q    <= gnt_q;
          gnt_q    <= '0;
          ptr_q    <= (gidx_q == IdxW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign ack        = ack_q;
  assign res_out    = res_q;
  assign borrow_out = borrow_q;
  assign dec_a      = dec_a_q;
  assign busy       = (state_q != StIdle);

endmodule
